// File: rtl/sr_readback_unpacker.sv
// rtl/sr_readback_unpacker.sv - snapshots SR readback after load_sr falls and streams it as WORD-bit words
// Optional SR_COMPARE_EN: registers a mismatch flag comparing each capture with the last din seen at start.
module sr_readback_unpacker #(
    parameter int WIDTH         = 170,
    parameter int WORD          = 16,
    parameter int CAPTURE_DELAY = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             load_sr,
    input  logic [WIDTH-1:0] dout,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic [WORD-1:0]  m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             overrun,
    output logic [7:0]       frame_cnt,
    output logic             mismatch
);
    localparam int NWORDS = (WIDTH + WORD - 1) / WORD;
    localparam int PW     = NWORDS * WORD;
    localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

    state_t          state;
    logic            load_d;
    logic [3:0]      dly;
    logic [IW-1:0]   widx;
    logic [PW-1:0]   shadow;
    logic [PW-1:0]   pad_dout;
    logic [IW-1:0]   widx_nxt;
    logic            fall;
    logic            capture;

    // Zero-extended so the tail of the last word reads 0 above WIDTH.
    assign pad_dout = PW'(dout);
    assign widx_nxt = widx + 1'b1;
    assign fall     = load_d & ~load_sr;
    assign capture  = (state == S_WAIT) && (dly == 4'd0);

    function automatic logic [WORD-1:0] word_at(input logic [PW-1:0] v, input logic [IW-1:0] i);
        return v[i*WORD +: WORD];
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= S_IDLE;
            load_d    <= 1'b0;
            dly       <= 4'd0;
            widx      <= '0;
            shadow    <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            load_d <= load_sr;
            // A frame end seen while still busy is dropped, only flagged.
            if (fall && state != S_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state <= S_WAIT;
                        busy  <= 1'b1;
                        dly   <= 4'(CAPTURE_DELAY - 1);
                    end
                end
                S_WAIT: begin
                    if (dly == 4'd0) begin
                        shadow  <= pad_dout;
                        state   <= S_SEND;
                        widx    <= '0;
                        m_valid <= 1'b1;
                        m_data  <= pad_dout[WORD-1:0];
                        m_last  <= (NWORDS == 1);
                    end else begin
                        dly <= dly - 4'd1;
                    end
                end
                S_SEND: begin
                    if (m_ready) begin
                        if (m_last) begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            m_valid   <= 1'b0;
                            m_last    <= 1'b0;
                            m_data    <= '0;
                            frame_cnt <= frame_cnt + 8'd1;
                        end else begin
                            widx   <= widx_nxt;
                            m_data <= word_at(shadow, widx_nxt);
                            m_last <= (widx_nxt == IW'(NWORDS - 1));
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SR_COMPARE_EN
    logic [WIDTH-1:0] expected;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            expected <= '0;
            mismatch <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                expected <= din;
            end
            if (capture) begin
                mismatch <= (dout != expected);
            end
        end
    end
`else
    logic unused_compare_inputs;
    assign unused_compare_inputs = ^{start, din, capture};
    assign mismatch = 1'b0;
`endif

endmodule
